// File: rtl/cnn_acc_feeder.sv
// cnn_acc_feeder: packs a streamed frame of weights and fmap for cnn_acc_ci,
// runs it, soft-resets the accumulator and hands the result downstream.
module cnn_acc_feeder #(
  parameter int DATA_LEN = 8,
  parameter int ICH      = 3,
  parameter int KX       = 3,
  parameter int KY       = 3,
  parameter int IX       = 7,
  parameter int IY       = 4,
  parameter int OX       = 5,
  parameter int OY       = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  input  logic [DATA_LEN-1:0]          s_data,
  output logic                         s_ready,
  output logic [ICH*KX*KY*DATA_LEN-1:0] o_cnn_weight,
  output logic [ICH*IX*IY*DATA_LEN-1:0] o_in_fmap,
  output logic                         o_in_valid,
  output logic                         o_soft_reset,
  input  logic                         i_ot_valid,
  input  logic [OX*OY*DATA_LEN-1:0]    i_ot_ci_acc,
  output logic                         o_res_valid,
  output logic [OX*OY*DATA_LEN-1:0]    o_res_data,
  input  logic                         i_res_ready,
  output logic                         o_busy,
  output logic                         o_err
);
  localparam int NW = ICH*KX*KY;
  localparam int NF = ICH*IX*IY;
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, RUN, SRST, SRST_ERR, RESULT} state_t;
  state_t        state_q;
  logic [6:0]    cnt_q;
  logic [TW-1:0] tmr_q;
  logic          beat;
  // s_ready is held low during reset so nothing is consumed by a discarded frame
  assign s_ready      = ~reset & (state_q inside {IDLE, LOAD_W, LOAD_F});
  assign beat         = s_valid & s_ready;
  assign o_in_valid   = state_q == RUN;
  assign o_soft_reset = state_q inside {SRST, SRST_ERR};
  assign o_res_valid  = state_q == RESULT;
  assign o_busy       = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmr_q        <= '0;
      o_cnn_weight <= '0;
      o_in_fmap    <= '0;
      o_res_data   <= '0;
      o_err        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (beat) begin
          o_cnn_weight[0 +: DATA_LEN] <= s_data;
          cnt_q   <= 7'(NW == 1 ? 0 : 1);
          state_q <= NW == 1 ? LOAD_F : LOAD_W;
        end
        LOAD_W: if (beat) begin
          o_cnn_weight[cnt_q*DATA_LEN +: DATA_LEN] <= s_data;
          cnt_q <= cnt_q == 7'(NW-1) ? '0 : cnt_q + 7'd1;
          if (cnt_q == 7'(NW-1)) state_q <= LOAD_F;
        end
        LOAD_F: if (beat) begin
          o_in_fmap[cnt_q*DATA_LEN +: DATA_LEN] <= s_data;
          cnt_q <= cnt_q == 7'(NF-1) ? '0 : cnt_q + 7'd1;
          if (cnt_q == 7'(NF-1)) begin
            state_q <= RUN;
            tmr_q   <= '0;
          end
        end
        RUN: begin
          tmr_q <= tmr_q + 1'b1;
          if (i_ot_valid) begin
            o_res_data <= i_ot_ci_acc;
            state_q    <= SRST;
          end else if (tmr_q == TW'(TIMEOUT-1)) begin
            o_err   <= 1'b1;
            state_q <= SRST_ERR;
          end
        end
        SRST:     state_q <= RESULT;
        SRST_ERR: state_q <= IDLE;
        RESULT:   if (i_res_ready) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_acc_feeder.sv
// tb_cnn_acc_feeder: scoreboard bench with a behavioural convolution stub
// standing in for cnn_acc_ci.
module tb_cnn_acc_feeder;
  localparam int NW = 27;
  localparam int NF = 84;
  logic         clk = 0, reset = 1, s_valid = 0, s_ready;
  logic [7:0]   s_data = 0;
  logic [215:0] o_cnn_weight;
  logic [671:0] o_in_fmap;
  logic         o_in_valid, o_soft_reset, i_ot_valid;
  logic [79:0]  i_ot_ci_acc, o_res_data;
  logic         o_res_valid, i_res_ready = 0, o_busy, o_err;
  int           checks = 0, errors = 0;
  int           resp_at = 0, run_cnt = 0, inv_n = 0, srst_n = 0, beats = 0, resv_n = 0;
  bit           spur = 0;
  longint       cyc = 0, cap_cyc = 0;
  logic [7:0]   wv[NW], fv[NF];
  logic [79:0]  sb[$];

  always #5 clk = ~clk;

  cnn_acc_feeder dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_cnn_weight(o_cnn_weight), .o_in_fmap(o_in_fmap), .o_in_valid(o_in_valid),
    .o_soft_reset(o_soft_reset), .i_ot_valid(i_ot_valid), .i_ot_ci_acc(i_ot_ci_acc),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .i_res_ready(i_res_ready),
    .o_busy(o_busy), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [79:0] conv(input logic [215:0] w, input logic [671:0] f);
    logic [79:0] r = '0;
    logic [7:0]  acc;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 5; ox++) begin
        acc = 0;
        for (int c = 0; c < 3; c++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              acc += w[(c*9+ky*3+kx)*8 +: 8] * f[(c*28+(oy+ky)*7+ox+kx)*8 +: 8];
        r[(oy*5+ox)*8 +: 8] = acc;
      end
    return r;
  endfunction

  // accumulator stub: answers on RUN cycle resp_at-1 (never when resp_at==0)
  assign i_ot_ci_acc = conv(o_cnn_weight, o_in_fmap);
  assign i_ot_valid  = spur | (o_in_valid && resp_at != 0 && run_cnt == resp_at - 1);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    run_cnt <= o_in_valid ? run_cnt + 1 : 0;
    if (o_in_valid) inv_n <= inv_n + 1;
    if (o_soft_reset) srst_n <= srst_n + 1;
    if (s_valid && s_ready) beats <= beats + 1;
    if (o_in_valid && i_ot_valid) cap_cyc <= cyc;
    if (!reset && o_res_valid && i_res_ready) begin
      resv_n <= resv_n + 1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("res_data", o_res_data, sb.pop_front());
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < NW; k++) wv[k] = mode == 0 ? 8'd1 : mode == 1 ? 8'(k) : 8'($urandom_range(0, 255));
    for (int k = 0; k < NF; k++) fv[k] = mode == 0 ? 8'd1 : mode == 1 ? 8'(k) : 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp();
    logic [215:0] w;
    logic [671:0] f;
    for (int k = 0; k < NW; k++) w[k*8 +: 8] = wv[k];
    for (int k = 0; k < NF; k++) f[k*8 +: 8] = fv[k];
    sb.push_back(conv(w, f));
  endtask

  task automatic send_beat(input logic [7:0] d, input bit gaps);
    int n = 0;
    if (gaps) while ($urandom_range(0, 1) == 1) begin
      s_valid = 0;
      @(negedge clk);
    end
    s_valid = 1;
    s_data  = d;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("beat_wait", 0, 1);
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic send_frame(input int start, input bit gaps);
    for (int k = start; k < NW + NF; k++) send_beat(k < NW ? wv[k] : fv[k-NW], gaps);
  endtask

  task automatic wait_res();
    int n = 0;
    while (!o_res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("res_wait", o_res_valid, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset   = 1;
    s_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int b0, v0, s0, r0, n;
    repeat (3) @(negedge clk);
    chk("rst_in_valid", o_in_valid, 0);
    chk("rst_srst", o_soft_reset, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_res_data", o_res_data, 0);
    chk("rst_weight", o_cnn_weight, 0);
    chk("rst_fmap", o_in_fmap, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_sready", s_ready, 1);
    // basic all-ones frame, result held under backpressure
    fill(0);
    push_exp();
    resp_at = 34;
    b0 = beats; v0 = inv_n; s0 = srst_n;
    send_frame(0, 0);
    chk("run_start", o_in_valid, 1);
    chk("busy_run", o_busy, 1);
    wait_res();
    chk("latency", cyc - cap_cyc, 2);
    chk("inv_cycles", inv_n - v0, 34);
    chk("srst_basic", srst_n - s0, 1);
    chk("res_basic", o_res_data, {10{8'h1B}});
    chk("beats_basic", beats - b0, 111);
    fill(1);
    push_exp();
    b0 = beats;
    s_valid = 1;
    s_data  = wv[0];
    repeat (20) begin
      @(negedge clk);
      chk("hold_valid", o_res_valid, 1);
      chk("hold_sready", s_ready, 0);
    end
    chk("hold_beats", beats - b0, 0);
    i_res_ready = 1;
    @(negedge clk);
    i_res_ready = 0;
    chk("res_drop", o_res_valid, 0);
    @(negedge clk);
    s_valid = 0;
    chk("idle_beat", beats - b0, 1);
    // packing frame continues from the beat accepted right after the handshake
    send_frame(1, 0);
    chk("pack_w26", o_cnn_weight[26*8 +: 8], 26);
    chk("pack_f83", o_in_fmap[83*8 +: 8], 83);
    chk("pack_w0", o_cnn_weight[7:0], 0);
    chk("pack_f0", o_in_fmap[7:0], 0);
    chk("pack_f40", o_in_fmap[40*8 +: 8], 40);
    i_res_ready = 1;
    wait_res();
    @(negedge clk);
    chk("pack_beats", beats - b0, 111);
    // random gaps, with i_ot_valid asserted outside RUN during the load
    fill(2);
    push_exp();
    b0 = beats;
    spur = 1;
    send_frame(0, 1);
    spur = 0;
    chk("gap_run", o_in_valid, 1);
    wait_res();
    @(negedge clk);
    chk("gap_beats", beats - b0, 111);
    // timeout
    fill(2);
    resp_at = 0;
    r0 = resv_n; v0 = inv_n; s0 = srst_n;
    send_frame(0, 0);
    n = 0;
    while (!o_soft_reset && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_srst", o_soft_reset, 1);
    chk("to_err", o_err, 1);
    chk("to_inv", inv_n - v0, 64);
    @(negedge clk);
    chk("to_srst_cnt", srst_n - s0, 1);
    chk("to_idle", o_busy, 0);
    chk("to_no_res", o_res_valid, 0);
    fill(2);
    push_exp();
    resp_at = 34;
    send_frame(0, 0);
    wait_res();
    @(negedge clk);
    chk("to_res_cnt", resv_n - r0, 1);
    chk("err_sticky", o_err, 1);
    // response on the final timer cycle wins over the timeout
    reset_dut();
    chk("err_cleared", o_err, 0);
    fill(2);
    push_exp();
    resp_at = 64;
    v0 = inv_n;
    send_frame(0, 0);
    wait_res();
    @(negedge clk);
    chk("sim_err", o_err, 0);
    chk("sim_inv", inv_n - v0, 64);
    // reset after 50 beats discards the partial frame
    resp_at = 34;
    fill(2);
    for (int k = 0; k < 50; k++) send_beat(wv[k], 0);
    s0 = srst_n;
    reset_dut();
    chk("mid_srst", srst_n - s0, 0);
    chk("mid_idle", o_busy, 0);
    fill(2);
    push_exp();
    send_frame(0, 0);
    wait_res();
    @(negedge clk);
    // reset while a result is pending
    fill(2);
    i_res_ready = 0;
    send_frame(0, 0);
    wait_res();
    s0 = srst_n;
    reset = 1;
    @(negedge clk);
    chk("rres_valid", o_res_valid, 0);
    chk("rres_data", o_res_data, 0);
    reset = 0;
    @(negedge clk);
    chk("rres_srst", srst_n - s0, 0);
    chk("rres_idle", o_busy, 0);
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_acc_feeder.md
Name: cnn_acc_feeder

Overview:
- Front-end loader and result drain for the cnn_acc_ci channel accumulator.
- Accepts a DATA_LEN-wide element stream from the HPS bridge using a valid/ready handshake. Packs the weight and fmap vectors, drives the accumulator's i_in_valid, and waits for its o_ot_valid.
- Captures the accumulated result, issues the soft reset the accumulator needs to leave DONE, and presents the result to the downstream reader with a valid/ready handshake.

Parameters:
- DATA_LEN, 8, element width in bits
- ICH, 3, input channels
- KX, 3, kernel width
- KY, 3, kernel height
- IX, 7, fmap width
- IY, 4, fmap height
- OX, 5, output width (IX-KX+1)
- OY, 2, output height (IY-KY+1)
- TIMEOUT, 64, maximum RUN cycles to wait for i_ot_valid

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input element valid
- s_data  in  DATA_LEN  input element
- s_ready  out  1  feeder accepts the element
- o_cnn_weight  out  ICH*KX*KY*DATA_LEN  packed weights to the accumulator
- o_in_fmap  out  ICH*IX*IY*DATA_LEN  packed fmap to the accumulator
- o_in_valid  out  1  accumulator start/hold
- o_soft_reset  out  1  accumulator soft reset pulse
- i_ot_valid  in  1  accumulator result valid
- i_ot_ci_acc  in  OX*OY*DATA_LEN  accumulator result
- o_res_valid  out  1  captured result valid
- o_res_data  out  OX*OY*DATA_LEN  captured result
- i_res_ready  in  1  downstream accepts the result
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky timeout flag

Behaviour:
- Reset is synchronous and active-high on clk, and takes priority over all other activity.
  - All outputs go to 0, including the packed vectors, o_res_data and o_err.
  - State goes to IDLE and the beat counter goes to 0.
  - Reset applied mid-frame discards any partial load or result with no soft-reset pulse.
- Beat transfer: a beat transfers on a cycle where s_valid & s_ready.
- Beat counter: 7 bits, counts transferred beats within the current frame.
- Frame order:
  - First NW = ICH*KX*KY (27) weight elements, then NF = ICH*IX*IY (84) fmap elements.
  - Element k of each vector is written to bits [k*DATA_LEN +: DATA_LEN].
  - Elements are packed channel-major, then row-major (y, then x), matching the accumulator slicing.
- s_ready = 1 in IDLE, LOAD_W and LOAD_F; 0 in all other states.
- States:
  - IDLE:
    - A transferred beat writes weight element 0, sets count=1 and goes to LOAD_W.
    - If NW==1, it goes directly to LOAD_F.
  - LOAD_W:
    - Each beat writes weight[count].
    - The beat with count==NW-1 goes to LOAD_F and clears count.
  - LOAD_F:
    - Each beat writes fmap[count].
    - The beat with count==NF-1 goes to RUN and clears the timer.
  - RUN:
    - o_in_valid=1 for every RUN cycle; o_cnn_weight and o_in_fmap are held stable.
    - The timer increments each cycle.
    - If i_ot_valid: latch i_ot_ci_acc into o_res_data, then go to SRST.
    - Else if timer==TIMEOUT-1: set o_err=1, then go to SRST_ERR.
    - When i_ot_valid and the timeout coincide, i_ot_valid wins and o_err is not set.
  - SRST:
    - o_soft_reset=1 and o_in_valid=0 for exactly 1 cycle.
    - Then go to RESULT.
  - SRST_ERR:
    - o_soft_reset=1 and o_in_valid=0 for exactly 1 cycle.
    - Then go to IDLE with no result presented.
  - RESULT:
    - o_res_valid=1 and o_res_data is held.
    - On i_res_ready, go to IDLE; o_res_valid drops the next cycle.
    - Holds indefinitely without i_res_ready; s_ready stays 0 (backpressure to the HPS).
- i_ot_valid outside RUN is ignored.
- s_valid while s_ready=0 is not consumed.
- Latency:
  - First RUN cycle is 1 cycle after the last fmap beat.
  - o_res_valid rises 2 cycles after the first RUN cycle with i_ot_valid: capture cycle, then SRST.
- Throughput: back-to-back frames are allowed. An IDLE beat on the cycle after RESULT handshake is accepted.
- o_err clears only on reset.
- Packed vectors are not cleared between frames; every element is overwritten by the next frame.

Test Plan:
- Basic frame: 27 weight beats of 1 and 84 fmap beats of 1, with a behavioural accumulator stub asserting i_ot_valid 34 cycles after o_in_valid rises with every element = 27 (0x1B).
  - o_in_valid high for exactly 34 cycles.
  - One o_soft_reset pulse.
  - o_res_data = ten bytes of 0x1B; o_res_valid held until i_res_ready.
- Packing: weight k = k, fmap k = k mod 256.
  - o_cnn_weight[26*8 +: 8]=26 and o_in_fmap[83*8 +: 8]=83 in RUN.
  - Byte 0 of each vector = 0.
- Stream gaps and backpressure:
  - s_valid toggled randomly during load: exactly 111 beats consumed.
  - Hold i_res_ready=0 for 20 cycles: s_ready=0 throughout and the 112th beat is not consumed until the handshake.
- Timeout: stub never responds.
  - After 64 RUN cycles, o_err=1 and one o_soft_reset pulse.
  - Return to IDLE with o_res_valid never asserted.
  - A next frame completes with o_err still 1.
- Simultaneous events: i_ot_valid on RUN cycle 64 (timer==63) -> result captured and o_err stays 0.
- Reset mid-operation:
  - Reset after beat 50: next frame's first beat is treated as weight 0.
  - Reset in RESULT: o_res_valid=0 the following cycle with no soft-reset pulse.
